// File: rtl/sdram_device_responder_if.sv
// sdram_device_responder_if: command and data bus between an sdram controller and the device model
interface sdram_device_responder_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12
);
   logic              io_sdram_control_cs;
   logic              io_sdram_control_ras;
   logic              io_sdram_control_cas;
   logic              io_sdram_control_we;
   logic [ADDR_W-1:0] io_sdram_control_address_bus;
   logic [DATA_W-1:0] io_dq_in;
   logic [DATA_W-1:0] io_dq_out;
   logic              io_dq_valid;
   logic [2:0]        io_state_out;
   logic              io_error;
   logic [7:0]        io_error_count;

   modport master (
      output io_sdram_control_cs, io_sdram_control_ras, io_sdram_control_cas, io_sdram_control_we,
      output io_sdram_control_address_bus, io_dq_in,
      input  io_dq_out, io_dq_valid, io_state_out, io_error, io_error_count
   );

   modport slave (
      input  io_sdram_control_cs, io_sdram_control_ras, io_sdram_control_cas, io_sdram_control_we,
      input  io_sdram_control_address_bus, io_dq_in,
      output io_dq_out, io_dq_valid, io_state_out, io_error, io_error_count
   );
endinterface

// File: rtl/sdram_device_responder.sv
// sdram_device_responder: single-bank sdram device model with row/timing tracking,
// burst read/write into a small array, CAS-latency read pipeline and error flagging.
module sdram_device_responder #(
   parameter int DATA_W = 16,
   parameter int ROW_W  = 4,
   parameter int COL_W  = 4,
   parameter int ADDR_W = 12,
   parameter int TRCD   = 2,
   parameter int TRP    = 2,
   parameter int TRFC   = 7
) (
   input logic                     clock,
   input logic                     reset,
   sdram_device_responder_if.slave io
);
   localparam int TW = $clog2(TRCD + TRP + TRFC) + 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_ACTIVATING = 3'd1, S_ACTIVE = 3'd2, S_PRECHARGING = 3'd3, S_REFRESHING = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      C_LOAD_MODE = 3'b000, C_REFRESH = 3'b001, C_PRECHARGE = 3'b010, C_ACTIVE = 3'b011,
      C_WRITE = 3'b100, C_READ = 3'b101, C_BST = 3'b110, C_NOP = 3'b111
   } cmd_e;

   state_e                     state_q, state_d;
   logic [TW-1:0]              timer_q, timer_d;
   logic [ROW_W-1:0]           row_q, row_d;
   logic [2:0]                 mask_q, mask_d;
   logic                       cl3_q, cl3_d;
   logic [2:0]                 brem_q, brem_d;
   logic [COL_W-1:0]           bcol_q, bcol_d;
   logic                       bwr_q, bwr_d;
   logic [DATA_W:0]            st2_q, st2_d, st1_q, st1_d, out_q, out_d;
   logic                       err_q, err_d;
   logic [7:0]                 cnt_q, cnt_d;
   logic [DATA_W-1:0]          mem [2**(ROW_W+COL_W)];
   cmd_e                       cmd;
   logic                       legal, mode_ok, do_rd, do_wr;
   logic [ADDR_W-1:0]          a;
   logic [COL_W-1:0]           op_col, cmask;
   logic [ROW_W+COL_W-1:0]     mem_addr;
   logic                       unused_addr;

   assign unused_addr = ^io.io_sdram_control_address_bus;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         row_q   <= '0;
         mask_q  <= '0;
         cl3_q   <= 1'b0;
         brem_q  <= '0;
         bcol_q  <= '0;
         bwr_q   <= 1'b0;
         st2_q   <= '0;
         st1_q   <= '0;
         out_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         row_q   <= row_d;
         mask_q  <= mask_d;
         cl3_q   <= cl3_d;
         brem_q  <= brem_d;
         bcol_q  <= bcol_d;
         bwr_q   <= bwr_d;
         st2_q   <= st2_d;
         st1_q   <= st1_d;
         out_q   <= out_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clock)
      if (!reset && do_wr) mem[mem_addr] <= io.io_dq_in;

   always_comb begin
      a       = io.io_sdram_control_address_bus;
      cmd     = io.io_sdram_control_cs ? C_NOP
              : cmd_e'({io.io_sdram_control_ras, io.io_sdram_control_cas, io.io_sdram_control_we});
      mode_ok = !a[2] && a[6:5] == 2'b01;
      legal   = cmd == C_NOP
              || (state_q == S_IDLE && (cmd inside {C_ACTIVE, C_PRECHARGE, C_REFRESH, C_BST}
                                        || (cmd == C_LOAD_MODE && mode_ok)))
              || (state_q == S_ACTIVE && cmd inside {C_READ, C_WRITE, C_PRECHARGE, C_BST});
      state_d = state_q;
      timer_d = timer_q;
      row_d   = row_q;
      mask_d  = mask_q;
      cl3_d   = cl3_q;
      if (state_q inside {S_ACTIVATING, S_PRECHARGING, S_REFRESHING}) begin
         timer_d = timer_q - TW'(1);
         if (timer_q == TW'(1)) state_d = state_q == S_ACTIVATING ? S_ACTIVE : S_IDLE;
      end
      if (legal)
         case (cmd)
            C_ACTIVE: begin
               state_d = TRCD == 1 ? S_ACTIVE : S_ACTIVATING;
               timer_d = TW'(TRCD - 1);
               row_d   = a[ROW_W-1:0];
            end
            C_PRECHARGE: begin
               state_d = TRP == 1 ? S_IDLE : S_PRECHARGING;
               timer_d = TW'(TRP - 1);
            end
            C_REFRESH: begin
               state_d = TRFC == 1 ? S_IDLE : S_REFRESHING;
               timer_d = TW'(TRFC - 1);
            end
            C_LOAD_MODE: begin
               mask_d = 3'((4'd1 << a[1:0]) - 4'd1);
               cl3_d  = a[4];
            end
            default: ;
         endcase
      // a new READ/WRITE restarts the burst; PRECHARGE/BST cut the running one short
      cmask  = COL_W'(mask_q);
      op_col = bcol_q;
      do_rd  = 1'b0;
      do_wr  = 1'b0;
      brem_d = brem_q;
      bwr_d  = bwr_q;
      if (legal && cmd inside {C_READ, C_WRITE}) begin
         op_col = a[COL_W-1:0];
         do_wr  = cmd == C_WRITE;
         do_rd  = cmd == C_READ;
         brem_d = mask_q;
         bwr_d  = cmd == C_WRITE;
      end else if (legal && cmd inside {C_PRECHARGE, C_BST}) begin
         brem_d = '0;
      end else if (brem_q != '0) begin
         do_wr  = bwr_q;
         do_rd  = !bwr_q;
         brem_d = brem_q - 3'd1;
      end
      bcol_d   = (op_col & ~cmask) | ((op_col + COL_W'(1)) & cmask);
      mem_addr = {row_q, op_col};
      // fetched words enter the delay line CL-1 stages ahead of the output register
      out_d = st1_q;
      st1_d = st2_q;
      st2_d = '0;
      if (legal && cmd == C_WRITE) begin
         out_d = '0;
         st1_d = '0;
      end
      if (do_rd && cl3_q) st2_d = {1'b1, mem[mem_addr]};
      if (do_rd && !cl3_q) st1_d = {1'b1, mem[mem_addr]};
      err_d = !legal;
      cnt_d = (!legal && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
   end

   always_comb begin
      io.io_dq_out      = out_q[DATA_W-1:0];
      io.io_dq_valid    = out_q[DATA_W];
      io.io_state_out   = state_q;
      io.io_error       = err_q;
      io.io_error_count = cnt_q;
   end
endmodule

// File: tb/tb_sdram_device_responder.sv
// tb_sdram_device_responder: directed command sequences; expected read words are queued
// with their due cycle and a negedge monitor matches them against io_dq_valid/io_dq_out.
module tb_sdram_device_responder;
   localparam logic [2:0] LMR = 3'b000, REF = 3'b001, PRE = 3'b010, ACT = 3'b011;
   localparam logic [2:0] WR = 3'b100, RD = 3'b101, BST = 3'b110, NOP = 3'b111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   int          exp_cyc[$];
   logic [15:0] exp_dat[$];
   int          m_c;
   logic [15:0] m_d;
   int          k;

   sdram_device_responder_if #(.DATA_W(16), .ADDR_W(12)) bus ();

   sdram_device_responder #(
      .DATA_W(16), .ROW_W(4), .COL_W(4), .ADDR_W(12), .TRCD(2), .TRP(2), .TRFC(7)
   ) dut (
      .clock(clk),
      .reset(rst),
      .io(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic cmd(input logic [2:0] op, input logic [11:0] a = '0, input logic [15:0] d = '0);
      @(negedge clk);
      bus.io_sdram_control_cs = (op == NOP);
      {bus.io_sdram_control_ras, bus.io_sdram_control_cas, bus.io_sdram_control_we} = op;
      bus.io_sdram_control_address_bus = a;
      bus.io_dq_in = d;
   endtask

   task automatic idle(input int n);
      repeat (n) cmd(NOP);
   endtask

   task automatic expect_rd(input logic [15:0] d, input int at);
      exp_dat.push_back(d);
      exp_cyc.push_back(at);
   endtask

   always @(negedge clk) begin
      if (bus.io_dq_valid) begin
         if (exp_dat.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read: got data %h at cycle %0d, no read due", bus.io_dq_out, cyc);
         end else begin
            m_c = exp_cyc.pop_front();
            m_d = exp_dat.pop_front();
            check("read_cycle", cyc, m_c);
            check("read_data", bus.io_dq_out, m_d);
         end
      end else begin
         check("dq_out_zero_when_invalid", bus.io_dq_out, 0);
      end
   end

   initial begin
      bus.io_sdram_control_cs = 1'b1;
      {bus.io_sdram_control_ras, bus.io_sdram_control_cas, bus.io_sdram_control_we} = NOP;
      bus.io_sdram_control_address_bus = '0;
      bus.io_dq_in = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_state", bus.io_state_out, 0);
      check("reset_valid", bus.io_dq_valid, 0);
      check("reset_error", bus.io_error, 0);
      check("reset_count", bus.io_error_count, 0);

      // basic write/read, BL=1 CL=2
      cmd(ACT, 12'd3);
      cmd(NOP);
      check("activating", bus.io_state_out, 1);
      cmd(WR, 12'd5, 16'hBEEF);
      check("active", bus.io_state_out, 2);
      cmd(RD, 12'd5);
      expect_rd(16'hBEEF, cyc + 2);
      idle(4);
      check("t1_count", bus.io_error_count, 0);

      // BL=4 CL=3 with wrap inside the aligned block
      cmd(PRE);
      cmd(NOP);
      check("precharging", bus.io_state_out, 3);
      cmd(NOP);
      check("pre_to_idle", bus.io_state_out, 0);
      cmd(LMR, 12'h032);
      cmd(ACT, 12'd1);
      cmd(NOP);
      cmd(WR, 12'd6, 16'd1);
      cmd(NOP, 12'd0, 16'd2);
      cmd(NOP, 12'd0, 16'd3);
      cmd(NOP, 12'd0, 16'd4);
      cmd(RD, 12'd6);
      k = cyc;
      for (int i = 0; i < 4; i++) expect_rd(16'(i + 1), k + 3 + i);
      idle(3);
      cmd(RD, 12'd4);
      k = cyc;
      expect_rd(16'd3, k + 3);
      expect_rd(16'd4, k + 4);
      expect_rd(16'd1, k + 5);
      expect_rd(16'd2, k + 6);
      idle(8);
      check("t2_count", bus.io_error_count, 0);

      // timing violations, row must stay 1
      cmd(PRE);
      idle(2);
      cmd(ACT, 12'd1);
      cmd(RD, 12'd5);
      cmd(ACT, 12'd3);
      check("early_read_error", bus.io_error, 1);
      check("early_read_count", bus.io_error_count, 1);
      cmd(RD, 12'd5);
      check("act_in_active_error", bus.io_error, 1);
      check("two_errors", bus.io_error_count, 2);
      k = cyc;
      expect_rd(16'd4, k + 3);
      expect_rd(16'd1, k + 4);
      expect_rd(16'd2, k + 5);
      expect_rd(16'd3, k + 6);
      cmd(NOP);
      check("error_one_cycle", bus.io_error, 0);
      idle(8);

      // BL=8 CL=2 read cut short by PRECHARGE, then refresh timing
      cmd(PRE);
      idle(2);
      cmd(LMR, 12'h023);
      cmd(ACT, 12'd1);
      cmd(NOP);
      cmd(WR, 12'd0, 16'h10);
      for (int i = 1; i < 8; i++) cmd(NOP, 12'd0, 16'(16'h10 + i));
      cmd(RD, 12'd2);
      k = cyc;
      expect_rd(16'h12, k + 2);
      expect_rd(16'h13, k + 3);
      expect_rd(16'h14, k + 4);
      cmd(NOP);
      cmd(NOP);
      cmd(PRE);
      cmd(NOP);
      check("interrupt_precharging", bus.io_state_out, 3);
      cmd(REF);
      check("interrupt_idle", bus.io_state_out, 0);
      for (int i = 1; i <= 7; i++) begin
         cmd(NOP);
         check("refresh_state", bus.io_state_out, i < 7 ? 4 : 0);
      end

      // illegal CL leaves mode (BL=8 CL=2) untouched
      cmd(LMR, 12'h050);
      cmd(NOP);
      check("bad_mode_error", bus.io_error, 1);
      check("bad_mode_count", bus.io_error_count, 3);
      cmd(ACT, 12'd1);
      cmd(NOP);
      cmd(RD, 12'd0);
      k = cyc;
      for (int i = 0; i < 8; i++) expect_rd(16'(16'h10 + i), k + 2 + i);
      idle(10);

      // saturation, then reset in the middle of a burst
      cmd(PRE);
      idle(2);
      repeat (300) cmd(RD, 12'd0);
      cmd(NOP);
      check("sat_error", bus.io_error, 1);
      check("sat_count", bus.io_error_count, 255);
      check("sat_state", bus.io_state_out, 0);
      cmd(ACT, 12'd1);
      cmd(NOP);
      cmd(RD, 12'd0);
      k = cyc;
      expect_rd(16'h10, k + 2);
      expect_rd(16'h11, k + 3);
      cmd(NOP);
      cmd(NOP);
      @(negedge clk);
      rst = 1'b1;
      bus.io_sdram_control_cs = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_valid", bus.io_dq_valid, 0);
      check("rst_state", bus.io_state_out, 0);
      check("rst_count", bus.io_error_count, 0);

      // reset restores BL=1 CL=2 and keeps the array
      cmd(ACT, 12'd1);
      cmd(NOP);
      cmd(RD, 12'd5);
      expect_rd(16'h15, cyc + 2);
      idle(6);
      check("queue_empty", exp_dat.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
